sram_host_seq: RTL and testbench

SRAM_HOST_SEQ -- requirements
Module: sram_host_seq

---
 rtl/sram_host_seq.sv | 206 ++++++++++++++++++++
 tb/tb_sram_host_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_host_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_host_seq
// Host-side command sequencer for a serial SRAM I/O controller. It accepts one
// read or write command at a time, then runs the controller through its
// phases. A write runs LOAD and SEND. A read runs LOAD, SEND and UNLOAD. Each
// phase ends in a wait for RDY, and a one-cycle BGN-low clear follows. A
// bounded wait aborts the command and reports RSP_ERR.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   CMD_VALID/READY     host command handshake (READY only in S_IDLE)
//   CMD_WR/ADDR/WDATA   command fields, latched on acceptance
//   RSP_VALID           one-cycle completion pulse
//   RSP_RDATA, RSP_ERR  read data (held until next accept), timeout flag
//   BGN                 controller enable, low for one cycle to clear it
//   LOAD_N              active-low one-cycle start strobe
//   CTRL                {is_write, is_sram} phase selector
//   SI / SO             serial frame out (LSB first) / serial readback in
//   RDY                 controller phase done
// -----------------------------------------------------------------------------
module sram_host_seq #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10,
  parameter int TIMEOUT_CYCLES    = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic                         CMD_WR,
  input  logic [MEMORY_ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [MEMORY_DATA_WIDTH-1:0] CMD_WDATA,
  output logic                         RSP_VALID,
  output logic [MEMORY_DATA_WIDTH-1:0] RSP_RDATA,
  output logic                         RSP_ERR,
  output logic                         BGN,
  output logic                         LOAD_N,
  output logic [1:0]                   CTRL,
  output logic                         SI,
  input  logic                         RDY,
  input  logic                         SO
);

  localparam int FRAME_W  = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int SHIFT_CW = $clog2(FRAME_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LDREQ, S_GAP, S_SHIFT, S_WAIT, S_CLR, S_SENDREQ, S_DONE
  } state_e;

  typedef enum logic [1:0] {PH_LOAD, PH_SEND, PH_UNLOAD} phase_e;

  state_e                       state_q, state_d;
  phase_e                       phase_q, phase_d;
  logic                         wr_q, wr_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEMORY_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MEMORY_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SHIFT_CW-1:0]          shift_cnt_q, shift_cnt_d;
  logic [5:0]                   wait_cnt_q, wait_cnt_d;
  logic                         err_q, err_d;
  logic [FRAME_W-1:0]           frame;

  // Address in the upper bits, data in the lower bits, so data goes out first.
  assign frame = {addr_q, wdata_q};

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_LOAD;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      shift_cnt_q <= '0;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      shift_cnt_q <= shift_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a latch.
    state_d     = state_q;
    phase_d     = phase_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    shift_cnt_d = shift_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (CMD_VALID) begin
          wr_d    = CMD_WR;
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WR ? CMD_WDATA : '0;  // reads load an all-zero data field
          rdata_d = '0;
          err_d   = 1'b0;
          phase_d = PH_LOAD;
          state_d = S_LDREQ;
        end
      end
      S_LDREQ: state_d = S_GAP;
      S_GAP: begin
        shift_cnt_d = '0;
        state_d     = S_SHIFT;
      end
      S_SHIFT: begin
        // Readback arrives LSB first: shift in at the top, after DATA_WIDTH
        // shifts the first bit has reached bit 0.
        if (phase_q == PH_UNLOAD && shift_cnt_q < SHIFT_CW'(MEMORY_DATA_WIDTH))
          rdata_d = {SO, rdata_q[MEMORY_DATA_WIDTH-1:1]};
        if (shift_cnt_q == SHIFT_CW'(FRAME_W - 1)) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // RDY wins over a timeout reached in the same cycle.
        if (RDY) begin
          state_d = S_CLR;
        end else if (wait_cnt_q == 6'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_CLR;
        end else begin
          wait_cnt_d = wait_cnt_q + 6'd1;
        end
      end
      S_CLR: begin
        if (err_q) begin
          state_d = S_DONE;
        end else begin
          unique case (phase_q)
            PH_LOAD: begin
              phase_d = PH_SEND;
              state_d = S_SENDREQ;
            end
            PH_SEND: begin
              if (wr_q) begin
                state_d = S_DONE;
              end else begin
                phase_d = PH_UNLOAD;
                state_d = S_LDREQ;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_SENDREQ: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: a pure decode of the registered state, so reset reaches the
  // outputs without waiting for a clock. READY and BGN also gate on RST
  // because S_IDLE (the reset state) would otherwise drive them high.
  always_comb begin
    CMD_READY = 1'b0;
    BGN       = 1'b0;
    LOAD_N    = 1'b1;
    CTRL      = 2'b00;
    SI        = 1'b0;
    RSP_VALID = 1'b0;
    RSP_RDATA = rdata_q;
    RSP_ERR   = err_q;

    if (!RST) begin
      CMD_READY = (state_q == S_IDLE);
      BGN       = (state_q != S_CLR);
    end
    if (state_q == S_LDREQ || state_q == S_SENDREQ)
      LOAD_N = 1'b0;
    // The send selector stays up through the wait that follows S_SENDREQ.
    if (state_q == S_SENDREQ || (state_q == S_WAIT && phase_q == PH_SEND))
      CTRL = {wr_q, 1'b1};
    if (state_q == S_SHIFT && phase_q == PH_LOAD)
      SI = frame[shift_cnt_q];
    if (state_q == S_DONE)
      RSP_VALID = 1'b1;
  end

endmodule

// File: tb/tb_sram_host_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_host_seq
// Bench for sram_host_seq with a cycle-level I/O-controller model. Expected
// responses (data, error, latency from acceptance) are queued when a command
// is accepted and compared when RSP_VALID pulses. Per-cycle traces of the
// controller strobes are compared for the reference write and read.
// -----------------------------------------------------------------------------
module tb_sram_host_seq;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int TMO    = 32;
  localparam int LAT_WR = 27;
  localparam int LAT_RD = 50;

  logic          CLK, RST;
  logic          CMD_VALID, CMD_READY, CMD_WR;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA, RSP_RDATA;
  logic          RSP_VALID, RSP_ERR, BGN, LOAD_N, SI, RDY, SO;
  logic [1:0]    CTRL;

  sram_host_seq #(
    .MEMORY_DATA_WIDTH(DW),
    .MEMORY_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .BGN(BGN), .LOAD_N(LOAD_N), .CTRL(CTRL), .SI(SI), .RDY(RDY), .SO(SO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- I/O controller model ----------------
  logic [DW-1:0] m_mem [1024];
  int            m_ld_wait = 1;   // wait cycles before RDY after a load shift
  int            m_ul_wait = 1;   // wait cycles before RDY after an unload shift

  initial begin : io_model
    bit            act, send, wr, unload, pend_rd;
    int            rel, k;
    logic [17:0]   frm;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mdata;
    act = 0; send = 0; wr = 0; unload = 0; pend_rd = 0; rel = 0;
    frm = '0; maddr = '0; mdata = '0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    m_mem[1] = 8'hA7;
    RDY = 1'b0;
    SO  = 1'b0;
    forever begin
      @(negedge CLK);
      RDY = 1'b0;
      SO  = 1'b0;
      if (RST || !BGN) begin
        act = 0;
        if (RST) pend_rd = 0;
      end else begin
        if (!LOAD_N) begin
          act    = 1;
          rel    = 1;
          send   = (CTRL != 2'b00);
          wr     = CTRL[1];
          unload = !send && pend_rd;
          if (unload) pend_rd = 0;
        end else if (act) begin
          rel++;
        end
        if (act && !send) begin
          if (rel >= 3 && rel <= 20) begin
            k      = rel - 3;
            frm[k] = SI;
            if (unload && k < DW) SO = m_mem[maddr][k];
          end
          if (rel == 20 + (unload ? m_ul_wait : m_ld_wait)) begin
            RDY = 1'b1;
            if (!unload) begin
              maddr = frm[17:8];
              mdata = frm[7:0];
            end
          end
        end else if (act && send) begin
          if (rel == (wr ? 3 : 4)) begin
            RDY = 1'b1;
            if (wr) m_mem[maddr] = mdata;
            else    pend_rd = 1;
          end
        end
      end
    end
  end

  // ---------------- trace recorder / LOAD_N run monitor ----------------
  int          trace_base = 1 << 20;
  logic [63:0] t_ln, t_bgn, t_c11, t_c01, t_si;
  int          ln_viol = 0;

  initial begin : recorder
    bit prev_low;
    int r;
    prev_low = 0;
    t_ln = '0; t_bgn = '0; t_c11 = '0; t_c01 = '0; t_si = '0;
    forever begin
      @(negedge CLK);
      if (!LOAD_N && prev_low) ln_viol++;
      prev_low = !LOAD_N;
      r = cyc - trace_base;
      if (r == 1) begin
        t_ln = '0; t_bgn = '0; t_c11 = '0; t_c01 = '0; t_si = '0;
      end
      if (r >= 1 && r < 64) begin
        t_ln[r]  = !LOAD_N;
        t_bgn[r] = !BGN;
        t_c11[r] = (CTRL == 2'b11);
        t_c01[r] = (CTRL == 2'b01);
        t_si[r]  = SI;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            acc;
  } exp_t;

  exp_t          sb [$];
  logic [DW-1:0] ref_mem [1024];

  initial begin : rsp_monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RSP_VALID) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(RSP_VALID), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", 64'(RSP_RDATA), 64'(e.rdata));
          check("rsp_err",   64'(RSP_ERR),   64'(e.err));
          check("rsp_lat",   64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input bit push, input logic exp_err, input int exp_lat, input bit keep);
    int   n;
    exp_t e;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    CMD_VALID = 1'b1;
    n = 0;
    while (!CMD_READY && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("ready_wait", 64'(n < 300), 64'd1);
    if (push) begin
      e.rdata = (wr || exp_err) ? '0 : ref_mem[addr];
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.acc   = cyc;
      sb.push_back(e);
      if (wr && !exp_err) ref_mem[addr] = wdata;
    end
    trace_base = cyc;
    @(posedge CLK);
    #1;
    if (!keep) CMD_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(negedge CLK);
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [15:0] out_vec();
    return {BGN, LOAD_N, CTRL, SI, RSP_VALID, RSP_RDATA, RSP_ERR, CMD_READY};
  endfunction

  localparam logic [15:0] RST_VEC = {1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] frm_exp;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rw;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    ref_mem[1] = 8'hA7;

    RST = 1'b0; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_WDATA = '0;
    #2 RST = 1'b1;
    #1 check("reset_outputs", 64'(out_vec()), 64'(RST_VEC));
    repeat (3) @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check("ready_after_reset", 64'(CMD_READY), 64'd1);

    // Reference write: strobes and serial frame cycle by cycle.
    send_cmd(1'b1, 10'h2A5, 8'h3C, 1, 1'b0, LAT_WR, 0);
    drain();
    frm_exp = 64'({10'h2A5, 8'h3C});
    check("wr_si",    t_si,  frm_exp << 3);
    check("wr_loadn", t_ln,  rng(1, 1) | rng(23, 23));
    check("wr_bgn",   t_bgn, rng(22, 22) | rng(26, 26));
    check("wr_ctrl11", t_c11, rng(23, 25));
    check("wr_ctrl01", t_c01, 64'd0);

    // Reference read; nonzero WDATA must not reach the frame.
    send_cmd(1'b0, 10'h001, 8'hFF, 1, 1'b0, LAT_RD, 0);
    drain();
    check("rd_si",     t_si,  64'd1 << 11);
    check("rd_loadn",  t_ln,  rng(1, 1) | rng(23, 23) | rng(28, 28));
    check("rd_bgn",    t_bgn, rng(22, 22) | rng(27, 27) | rng(49, 49));
    check("rd_ctrl01", t_c01, rng(23, 26));
    check("rd_ctrl11", t_c11, 64'd0);
    repeat (3) @(negedge CLK);
    check("rdata_hold", 64'(RSP_RDATA), 64'h0A7);

    // Load phase never completes: timeout, then normal operation resumes.
    m_ld_wait = 999;
    send_cmd(1'b1, 10'h010, 8'h55, 1, 1'b1, 20 + TMO + 2, 0);
    drain();
    m_ld_wait = 1;
    send_cmd(1'b0, 10'h010, 8'h00, 1, 1'b0, LAT_RD, 0);
    send_cmd(1'b0, 10'h2A5, 8'h00, 1, 1'b0, LAT_RD, 0);
    drain();

    // RDY in the last allowed wait cycle still succeeds.
    m_ld_wait = TMO;
    send_cmd(1'b1, 10'h020, 8'hC3, 1, 1'b0, LAT_WR + TMO - 1, 0);
    drain();
    m_ld_wait = 1;

    // Unload phase times out: data already shifted in must be discarded.
    m_ul_wait = 999;
    send_cmd(1'b0, 10'h020, 8'h00, 1, 1'b1, 47 + TMO + 2, 0);
    drain();
    m_ul_wait = 1;
    send_cmd(1'b0, 10'h020, 8'h00, 1, 1'b0, LAT_RD, 0);
    drain();

    // Back-to-back with CMD_VALID held high, including the top address.
    send_cmd(1'b1, 10'h3FF, 8'hEE, 1, 1'b0, LAT_WR, 1);
    send_cmd(1'b0, 10'h3FF, 8'h00, 1, 1'b0, LAT_RD, 1);
    send_cmd(1'b1, 10'h000, 8'h11, 1, 1'b0, LAT_WR, 1);
    send_cmd(1'b0, 10'h000, 8'h00, 1, 1'b0, LAT_RD, 0);
    drain();

    // A few random commands.
    for (int i = 0; i < 6; i++) begin
      rw = 1'($urandom_range(0, 1));
      ra = AW'($urandom_range(0, 1023));
      rd = DW'($urandom_range(0, 255));
      send_cmd(rw, ra, rd, 1, 1'b0, rw ? LAT_WR : LAT_RD, 0);
    end
    drain();

    // Reset in cycle 10 of a write: immediate reset outputs, no response.
    send_cmd(1'b1, 10'h055, 8'h99, 0, 1'b0, 0, 0);
    repeat (10) @(negedge CLK);
    #1 RST = 1'b1;
    #1 check("midcmd_reset_outputs", 64'(out_vec()), 64'(RST_VEC));
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check("ready_after_midreset", 64'(CMD_READY), 64'd1);
    send_cmd(1'b0, 10'h055, 8'h00, 1, 1'b0, LAT_RD, 0);
    send_cmd(1'b0, 10'h001, 8'h00, 1, 1'b0, LAT_RD, 0);
    drain();

    check("loadn_run", 64'(ln_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
